// File: rtl/axi4s_packet_framer_pkg.sv
// Shared types and length helpers for axi4s_packet_framer and its benches.
// Lengths are passed as 32-bit values and the shift as log2(bytes per word).
package axi4s_packet_framer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    // ceil(len / 2^sh), computed one bit wider so the round-up add cannot wrap
    function automatic logic [31:0] len2words(input logic [31:0] len, input int unsigned sh);
        logic [32:0] sum;
        sum = {1'b0, len} + ((33'd1 << sh) - 33'd1);
        return 32'(sum >> sh);
    endfunction

    function automatic logic [31:0] len2trailing(input logic [31:0] len, input int unsigned sh);
        return len & ((32'd1 << sh) - 32'd1);
    endfunction

endpackage

// File: rtl/axi4s_packet_framer.sv
// Frames an unframed AXI4-Stream byte stream into packets using a separate length channel.
// Optional one-entry length prefetch: define AXI4S_PACKET_FRAMER_LEN_PREFETCH_EN.
module axi4s_packet_framer
    import axi4s_packet_framer_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int LEN_WIDTH      = 16,
    parameter int TRAILING_WIDTH = $clog2(DATA_WIDTH / 8)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LEN_WIDTH-1:0]      len_tdata,
    input  logic                      len_tvalid,
    output logic                      len_tready,
    input  logic [DATA_WIDTH-1:0]     i_tdata,
    input  logic                      i_tvalid,
    output logic                      i_tready,
    output logic [DATA_WIDTH-1:0]     o_tdata,
    output logic [TRAILING_WIDTH-1:0] o_tuser,
    output logic                      o_tlast,
    output logic                      o_tvalid,
    input  logic                      o_tready,
    output logic                      err_zero_len
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int SH     = $clog2(BYTES);
    localparam int WCNT_W = LEN_WIDTH - SH + 1;

    state_t                    state, state_nxt;
    logic [WCNT_W-1:0]         words_left, words_left_nxt;
    logic [TRAILING_WIDTH-1:0] trail, trail_nxt;
    logic                      err_nxt;

    logic                      in_data;
    logic                      len_hs;
    logic                      out_hs;
    logic                      last_hs;
    logic [LEN_WIDTH-1:0]      ld_len;
    logic [WCNT_W-1:0]         ld_words;
    logic [TRAILING_WIDTH-1:0] ld_trail;

`ifdef AXI4S_PACKET_FRAMER_LEN_PREFETCH_EN
    logic                 pend_valid, pend_valid_nxt;
    logic [LEN_WIDTH-1:0] pend_len, pend_len_nxt;

    assign len_tready = !rst && !pend_valid;
    assign ld_len     = pend_valid ? pend_len : len_tdata;
`else
    assign len_tready = !rst && (state == IDLE);
    assign ld_len     = len_tdata;
`endif

    // Payload is a straight wire while a packet is open; nothing moves otherwise.
    assign in_data  = (state == DATA);
    assign o_tdata  = i_tdata;
    assign o_tvalid = in_data && i_tvalid;
    assign i_tready = in_data && o_tready;
    assign o_tlast  = in_data && (words_left == WCNT_W'(1));
    assign o_tuser  = o_tlast ? trail : '0;

    assign len_hs   = len_tvalid && len_tready;
    assign out_hs   = o_tvalid && o_tready;
    assign last_hs  = out_hs && o_tlast;

    assign ld_words = WCNT_W'(len2words(32'(ld_len), SH));
    assign ld_trail = TRAILING_WIDTH'(len2trailing(32'(ld_len), SH));

    always_comb begin
        state_nxt      = state;
        words_left_nxt = words_left;
        trail_nxt      = trail;
        err_nxt        = 1'b0;
`ifdef AXI4S_PACKET_FRAMER_LEN_PREFETCH_EN
        pend_valid_nxt = pend_valid;
        pend_len_nxt   = pend_len;
`endif
        case (state)
            IDLE: begin
                if (len_hs) begin
                    if (len_tdata == '0) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt      = DATA;
                        words_left_nxt = ld_words;
                        trail_nxt      = ld_trail;
                    end
                end
            end
            DATA: begin
                if (out_hs) begin
                    words_left_nxt = words_left - WCNT_W'(1);
                end
`ifdef AXI4S_PACKET_FRAMER_LEN_PREFETCH_EN
                if (len_hs) begin
                    pend_valid_nxt = 1'b1;
                    pend_len_nxt   = len_tdata;
                end
                // A descriptor captured in this very cycle chains just like a stored one.
                if (last_hs) begin
                    if (pend_valid || len_hs) begin
                        pend_valid_nxt = 1'b0;
                        if (ld_len == '0) begin
                            err_nxt   = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            words_left_nxt = ld_words;
                            trail_nxt      = ld_trail;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
`else
                if (last_hs) begin
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            words_left   <= '0;
            trail        <= '0;
            err_zero_len <= 1'b0;
`ifdef AXI4S_PACKET_FRAMER_LEN_PREFETCH_EN
            pend_valid   <= 1'b0;
            pend_len     <= '0;
`endif
        end else begin
            state        <= state_nxt;
            words_left   <= words_left_nxt;
            trail        <= trail_nxt;
            err_zero_len <= err_nxt;
`ifdef AXI4S_PACKET_FRAMER_LEN_PREFETCH_EN
            pend_valid   <= pend_valid_nxt;
            pend_len     <= pend_len_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_axi4s_packet_framer.sv
// Randomized self-checking bench for axi4s_packet_framer (DATA_WIDTH=64).
// Expected idle gaps follow AXI4S_PACKET_FRAMER_LEN_PREFETCH_EN when it is defined.
module tb_axi4s_packet_framer;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [2:0]  user;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] len_tdata = '0;
    logic        len_tvalid = 1'b0;
    logic        len_tready;
    logic [63:0] i_tdata = '0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [63:0] o_tdata;
    logic [2:0]  o_tuser;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic        err_zero_len;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] src_q[$];
    int          len_q[$];
    beat_t       obs_q[$];
    beat_t       exp_q[$];

    bit gap_en   = 1'b0;
    bit rdy_rand = 1'b0;
    bit rdy_hold = 1'b0;

    int cyc         = 0;
    int err_cnt     = 0;
    int err_cyc     = -1;
    int err_run     = 0;
    int err_run_max = 0;
    int lenhs_cyc   = -1;
    int itready_cnt = 0;

    axi4s_packet_framer #(
        .DATA_WIDTH(64),
        .LEN_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .len_tdata   (len_tdata),
        .len_tvalid  (len_tvalid),
        .len_tready  (len_tready),
        .i_tdata     (i_tdata),
        .i_tvalid    (i_tvalid),
        .i_tready    (i_tready),
        .o_tdata     (o_tdata),
        .o_tuser     (o_tuser),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .err_zero_len(err_zero_len)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Payload source: holds a word until accepted, optional random gaps.
    initial begin : payload_drv
        bit hs;
        forever begin
            @(negedge clk);
            hs = i_tvalid && i_tready;
            @(posedge clk);
            #1;
            if (hs) begin
                void'(src_q.pop_front());
                i_tvalid = 1'b0;
            end
            if (!i_tvalid && src_q.size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
                i_tvalid = 1'b1;
                i_tdata  = src_q[0];
            end
        end
    end

    initial begin : length_drv
        bit hs;
        forever begin
            @(negedge clk);
            hs = len_tvalid && len_tready;
            @(posedge clk);
            #1;
            if (hs) begin
                void'(len_q.pop_front());
                len_tvalid = 1'b0;
            end
            if (!len_tvalid && len_q.size() > 0) begin
                len_tvalid = 1'b1;
                len_tdata  = 16'(len_q[0]);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        o_tready = rdy_hold ? 1'b0 : (rdy_rand ? ($urandom_range(1) == 1) : 1'b1);
    end

    // Passive monitor: records accepted beats and event timing.
    initial forever begin
        @(negedge clk);
        if (o_tvalid && o_tready) obs_q.push_back('{o_tdata, o_tlast, o_tuser, cyc});
        if (len_tvalid && len_tready) lenhs_cyc = cyc;
        if (err_zero_len) begin
            err_cnt++;
            err_cyc = cyc;
            err_run++;
            if (err_run > err_run_max) err_run_max = err_run;
        end else begin
            err_run = 0;
        end
        if (i_tready) itready_cnt++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model: a packet of L bytes is ceil(L/8) words, tuser = L mod 8 on the last one.
    task automatic send_packet(input int len);
        int nw;
        logic [63:0] w;
        beat_t b;
        nw = (len + 7) / 8;
        len_q.push_back(len);
        for (int k = 0; k < nw; k++) begin
            w = {$urandom, $urandom};
            src_q.push_back(w);
            b.data = w;
            b.last = (k == nw - 1);
            b.user = (k == nw - 1) ? 3'(len % 8) : 3'd0;
            b.cyc  = 0;
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int t = 0;
        while (obs_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        repeat (10) tick();
        vectors++;
        if (obs_q.size() != n) begin
            miscompares++;
            $display("[TB] FAIL %s beat_count got %0d want %0d", name, obs_q.size(), n);
        end
    endtask

    task automatic start_test(input bit gaps, input bit rnd);
        gap_en   = gaps;
        rdy_rand = rnd;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if (len_tready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_len_tready_in_rst got %b want 0", len_tready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        vectors += 5;
        if (o_tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_o_tvalid got %b want 0", o_tvalid); end
        if (o_tlast !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_o_tlast got %b want 0", o_tlast); end
        if (o_tuser !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_o_tuser got %0d want 0", o_tuser); end
        if (err_zero_len !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got %b want 0", err_zero_len); end
        if (len_tready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_len_tready_after got %b want 1", len_tready); end
    endtask

    task automatic test_single_beat();
        start_test(1'b0, 1'b0);
        send_packet(8);
        wait_beats(1, 50, "single_beat");
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            vectors++;
            if (obs_q[k].data !== exp_q[k].data || obs_q[k].last !== 1'b1 || obs_q[k].user !== 3'd0) begin
                miscompares++;
                $display("[TB] FAIL single_beat data=%h last=%b user=%0d want data=%h last=1 user=0",
                         obs_q[k].data, obs_q[k].last, obs_q[k].user, exp_q[k].data);
            end
        end
    endtask

    task automatic test_two_beat();
        start_test(1'b0, 1'b0);
        send_packet(13);
        wait_beats(2, 50, "two_beat");
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            vectors++;
            if (obs_q[k].data !== exp_q[k].data || obs_q[k].last !== exp_q[k].last ||
                obs_q[k].user !== exp_q[k].user) begin
                miscompares++;
                $display("[TB] FAIL two_beat[%0d] got %h/%b/%0d want %h/%b/%0d", k, obs_q[k].data,
                         obs_q[k].last, obs_q[k].user, exp_q[k].data, exp_q[k].last, exp_q[k].user);
            end
        end
    endtask

    task automatic test_zero_len();
        int e0, it0, t;
        start_test(1'b0, 1'b0);
        e0  = err_cnt;
        it0 = itready_cnt;
        err_run_max = 0;
        send_packet(0);
        t = 0;
        while (err_cnt == e0 && t < 50) begin
            tick();
            t++;
        end
        repeat (5) tick();
        vectors += 4;
        if (err_cnt - e0 != 1) begin
            miscompares++;
            $display("[TB] FAIL zero_len_pulses got %0d want 1", err_cnt - e0);
        end
        if (err_run_max != 1) begin
            miscompares++;
            $display("[TB] FAIL zero_len_width got %0d want 1", err_run_max);
        end
        if (err_cyc != lenhs_cyc + 1) begin
            miscompares++;
            $display("[TB] FAIL zero_len_timing err_cyc %0d want %0d", err_cyc, lenhs_cyc + 1);
        end
        if (itready_cnt != it0) begin
            miscompares++;
            $display("[TB] FAIL zero_len_i_tready got %0d cycles want 0", itready_cnt - it0);
        end
        send_packet(1);
        wait_beats(1, 50, "zero_len_next");
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            vectors++;
            if (obs_q[k].data !== exp_q[k].data || obs_q[k].last !== 1'b1 || obs_q[k].user !== 3'd1) begin
                miscompares++;
                $display("[TB] FAIL zero_len_next got %h/%b/%0d want %h/1/1",
                         obs_q[k].data, obs_q[k].last, obs_q[k].user, exp_q[k].data);
            end
        end
    endtask

    task automatic test_gapped_64();
        start_test(1'b1, 1'b1);
        send_packet(64);
        wait_beats(8, 400, "gapped_64");
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            vectors++;
            if (obs_q[k].data !== exp_q[k].data || obs_q[k].last !== exp_q[k].last ||
                obs_q[k].user !== exp_q[k].user) begin
                miscompares++;
                $display("[TB] FAIL gapped_64[%0d] got %h/%b/%0d want %h/%b/%0d", k, obs_q[k].data,
                         obs_q[k].last, obs_q[k].user, exp_q[k].data, exp_q[k].last, exp_q[k].user);
            end
        end
    endtask

    task automatic test_back_to_back();
        int gap, want_gap;
`ifdef AXI4S_PACKET_FRAMER_LEN_PREFETCH_EN
        want_gap = 0;
`else
        want_gap = 1;
`endif
        start_test(1'b0, 1'b0);
        send_packet(3);
        send_packet(17);
        wait_beats(4, 100, "back_to_back");
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            vectors++;
            if (obs_q[k].data !== exp_q[k].data || obs_q[k].last !== exp_q[k].last ||
                obs_q[k].user !== exp_q[k].user) begin
                miscompares++;
                $display("[TB] FAIL back_to_back[%0d] got %h/%b/%0d want %h/%b/%0d", k, obs_q[k].data,
                         obs_q[k].last, obs_q[k].user, exp_q[k].data, exp_q[k].last, exp_q[k].user);
            end
        end
        if (obs_q.size() >= 2) begin
            gap = obs_q[1].cyc - obs_q[0].cyc - 1;
            vectors++;
            if (gap != want_gap) begin
                miscompares++;
                $display("[TB] FAIL back_to_back_gap got %0d idle cycles want %0d", gap, want_gap);
            end
        end
    endtask

    task automatic test_random();
        int e0, zeros, len;
        start_test(1'b1, 1'b1);
        e0 = err_cnt;
        zeros = 0;
        for (int p = 0; p < 14; p++) begin
            len = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(70, 1));
            if (len == 0) zeros++;
            send_packet(len);
        end
        wait_beats(exp_q.size(), 3000, "random");
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            vectors++;
            if (obs_q[k].data !== exp_q[k].data || obs_q[k].last !== exp_q[k].last ||
                obs_q[k].user !== exp_q[k].user) begin
                miscompares++;
                $display("[TB] FAIL random[%0d] got %h/%b/%0d want %h/%b/%0d", k, obs_q[k].data,
                         obs_q[k].last, obs_q[k].user, exp_q[k].data, exp_q[k].last, exp_q[k].user);
            end
        end
        vectors++;
        if (err_cnt - e0 != zeros) begin
            miscompares++;
            $display("[TB] FAIL random_err_count got %0d want %0d", err_cnt - e0, zeros);
        end
    endtask

    task automatic test_reset_mid_packet();
        int t;
        logic [63:0] w8;
        start_test(1'b0, 1'b0);
        len_q.push_back(32);
        src_q.push_back({$urandom, $urandom});
        src_q.push_back({$urandom, $urandom});
        t = 0;
        while (obs_q.size() < 2 && t < 50) begin
            tick();
            t++;
        end
        vectors++;
        if (obs_q.size() != 2) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_pre_beats got %0d want 2", obs_q.size());
        end
        // Stall the sink and offer a fresh word so that post-reset gating is visible.
        rdy_hold = 1'b1;
        w8 = {$urandom, $urandom};
        src_q.push_back(w8);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        vectors++;
        if (len_tready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_len_tready_in_rst got %b want 0", len_tready);
        end
        rdy_hold = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        vectors += 4;
        if (o_tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_o_tvalid got %b want 0", o_tvalid); end
        if (i_tready !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_i_tready got %b want 0", i_tready); end
        if (o_tlast !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_o_tlast got %b want 0", o_tlast); end
        if (len_tready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_reset_len_tready got %b want 1", len_tready); end
        obs_q.delete();
        len_q.push_back(8);
        exp_q.push_back('{w8, 1'b1, 3'd0, 0});
        wait_beats(1, 50, "mid_reset_next");
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            vectors++;
            if (obs_q[k].data !== exp_q[k].data || obs_q[k].last !== 1'b1 || obs_q[k].user !== 3'd0) begin
                miscompares++;
                $display("[TB] FAIL mid_reset_next got %h/%b/%0d want %h/1/0",
                         obs_q[k].data, obs_q[k].last, obs_q[k].user, exp_q[k].data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_two_beat();
        test_zero_len();
        test_gapped_64();
        test_back_to_back();
        test_random();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
